// File: rtl/bin_to_bcd_digits_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared types and helpers for the binary-to-BCD digit converter.
//   bcd_digit_t    one BCD digit (0-9, or BCD_BLANK for a blanked position)
//   b2b_state_t    converter FSM states
//   BCD_BLANK      digit code the LED driver renders as an unlit position
//   pow10_minus1   largest value that fits in n decimal digits
// ---------------------------------------------------------------------------
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } b2b_state_t;

  localparam bcd_digit_t BCD_BLANK = 4'hF;

  // Evaluated at elaboration time only, to form the overflow limit.
  function automatic logic [63:0] pow10_minus1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_digits_if.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_digits_if
// Request/result bundle between a client and the BCD converter.
//   start     client -> converter  conversion request
//   bin_in    client -> converter  unsigned binary value
//   busy      converter -> client  conversion in progress
//   done      converter -> client  one-cycle pulse when results update
//   overflow  converter -> client  last value did not fit in NUM_DIGITS
//   digits    converter -> client  registered BCD digits, [0] = least significant
// master = client side, slave = converter side.
// ---------------------------------------------------------------------------
interface bin_to_bcd_digits_if
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH  = 27,
  parameter int NUM_DIGITS = 8
);

  logic                 start;
  logic [BIN_WIDTH-1:0] bin_in;
  logic                 busy;
  logic                 done;
  logic                 overflow;
  bcd_digit_t           digits [NUM_DIGITS];

  modport master (
    output start, bin_in,
    input  busy, done, overflow, digits
  );

  modport slave (
    input  start, bin_in,
    output busy, done, overflow, digits
  );

endinterface

// File: rtl/bin_to_bcd_digits_dabble.sv
// ---------------------------------------------------------------------------
// bcd_dabble_digit
// Combinational double-dabble correction for one BCD nibble: a nibble of 5
// or more gets 3 added so the following left shift carries correctly into
// the next decimal digit. Valid inputs are 0-9, so the sum stays within 4'd12.
//   i_nibble  in   scratch BCD nibble before the shift
//   o_nibble  out  corrected nibble
// ---------------------------------------------------------------------------
module bcd_dabble_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t i_nibble,
  output bcd_digit_t o_nibble
);

  assign o_nibble = (i_nibble >= 4'd5) ? (i_nibble + 4'd3) : i_nibble;

endmodule

// File: rtl/bin_to_bcd_digits.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_digits
// Iterative double-dabble converter. An accepted request is shifted through
// the scratch register one bit per clock (BIN_WIDTH cycles), then the result
// is copied into the output digit registers in the DONE cycle. The outputs
// hold the previous result for the whole conversion, so a display fed from
// them never shows intermediate values.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-high reset
//   bus    slave side of bin_to_bcd_digits_if (start/bin_in in,
//          busy/done/overflow/digits out)
// Build option: LEADING_ZERO_BLANK_EN replaces leading zero digits (all but
// digits[0]) with BCD_BLANK. Saturated overflow results are never blanked.
// ---------------------------------------------------------------------------
module bin_to_bcd_digits
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH  = 27,
  parameter int NUM_DIGITS = 8
)(
  input  logic                  clk,
  input  logic                  reset,
  bin_to_bcd_digits_if.slave    bus
);

  localparam int               SCR_W      = NUM_DIGITS * 4;
  localparam int               CNT_W      = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BIN_WIDTH - 1);
  localparam logic [63:0]      OVF_LIMIT  = pow10_minus1(NUM_DIGITS);

  b2b_state_t           r_state;
  logic [CNT_W-1:0]     r_count;
  logic [SCR_W-1:0]     r_scratch;
  logic [BIN_WIDTH-1:0] r_bin;
  logic                 r_ovfPending;
  logic                 r_overflow;
  bcd_digit_t           r_digits [NUM_DIGITS];

  logic [SCR_W-1:0]           w_corrected;
  logic [SCR_W+BIN_WIDTH-1:0] w_shifted;
  bcd_digit_t                 w_result [NUM_DIGITS];

  // One correction cell per scratch nibble; all nibbles are corrected in
  // parallel before the combined shift.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dabble
    bcd_dabble_digit u_dabble (
      .i_nibble (r_scratch[4*g +: 4]),
      .o_nibble (w_corrected[4*g +: 4])
    );
  end

  // The scratch BCD and the remaining binary bits shift as one long register.
  // Anything pushed out of the top nibble only happens for values that are
  // saturated anyway.
  assign w_shifted = {w_corrected, r_bin} << 1;

  // Final digits as they will look after the last shift: plain BCD, optionally
  // with leading zeros blanked, or all nines when the value did not fit.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_result[i] = w_shifted[BIN_WIDTH + 4*i +: 4];
    end
`ifdef LEADING_ZERO_BLANK_EN
    begin : blank_leading
      logic seenNonZero;
      seenNonZero = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        if (w_result[i] != 4'd0) begin
          seenNonZero = 1'b1;
        end else if (!seenNonZero) begin
          w_result[i] = BCD_BLANK;
        end
      end
    end
`endif
    if (r_ovfPending) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        w_result[i] = 4'd9;
      end
    end
  end

  // Control FSM and datapath registers. Requests are only looked at in IDLE,
  // so a start during CONVERT or DONE is simply dropped. The overflow compare
  // is done on the raw input at accept time, because the truncated scratch
  // register cannot tell an overflowing value apart. Output registers load on
  // the terminal shift, which makes them valid during the DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_scratch    <= '0;
      r_bin        <= '0;
      r_ovfPending <= 1'b0;
      r_overflow   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_digits[i] <= 4'd0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state      <= CONVERT;
            r_count      <= '0;
            r_scratch    <= '0;
            r_bin        <= bus.bin_in;
            r_ovfPending <= (64'(bus.bin_in) > OVF_LIMIT);
          end
        end
        CONVERT: begin
          r_scratch <= w_shifted[SCR_W+BIN_WIDTH-1 -: SCR_W];
          r_bin     <= w_shifted[BIN_WIDTH-1:0];
          if (r_count == LAST_COUNT) begin
            r_state    <= DONE;
            r_count    <= '0;
            r_overflow <= r_ovfPending;
            for (int i = 0; i < NUM_DIGITS; i++) begin
              r_digits[i] <= w_result[i];
            end
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = (r_state == DONE);
  assign bus.overflow = r_overflow;
  assign bus.digits   = r_digits;

endmodule
